// File: rtl/scram_arbiter_pkg.sv
// Shared types and helpers for the scram port arbiter.
package scram_arbiter_pkg;

  // Arbiter sequencing: grant in IDLE, one enable cycle in ISSUE,
  // wait for the RAM in WAIT, one ready cycle in RESP.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = (n > 0) ? n - 1 : 0; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scram_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ. ptr is expected to be below NREQ.
module scram_rr_picker
  import scram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any_req
);

  logic [NREQ-1:0] rot;
  logic [IDXW-1:0] off;
  logic [IDXW:0]   sum;

  // Rotate requests so ptr lands on bit 0, find the first set bit, then
  // rotate the offset back into an absolute requester index.
  always_comb begin
    rot     = NREQ'({req, req} >> ptr);
    any_req = 1'b0;
    off     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && rot[i]) begin
        any_req = 1'b1;
        off     = IDXW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDXW + 1)'(NREQ)) begin
      sum = sum - (IDXW + 1)'(NREQ);
    end
    gnt_idx = sum[IDXW-1:0];
    gnt     = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      gnt[j] = any_req && (gnt_idx == IDXW'(j));
    end
  end

endmodule

// File: rtl/scram_arbiter.sv
// Round-robin arbiter sharing one scram RAM port between NREQ requesters.
// Each access: one ram_en cycle, wait for ram_ready, one req_ready pulse.
module scram_arbiter
  import scram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned ADDRW = 4,
  parameter int unsigned DATAW = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NREQ-1:0]             req_en,
  input  logic [NREQ-1:0]             req_wr,
  input  logic [NREQ*ADDRW-1:0]       req_addr,
  input  logic [NREQ*DATAW-1:0]       req_wdata,
  input  logic [NREQ*(DATAW/8)-1:0]   req_strb,
  output logic [NREQ-1:0]             req_ready,
  output logic [DATAW-1:0]            req_rdata,
  output logic                        ram_en,
  output logic                        ram_wr,
  output logic [ADDRW-1:0]            ram_addr,
  output logic [DATAW-1:0]            ram_wdata,
  output logic [DATAW/8-1:0]          ram_strb,
  input  logic [DATAW-1:0]            ram_rdata,
  input  logic                        ram_ready
);

  localparam int unsigned IDXW  = idx_width(NREQ);
  localparam int unsigned STRBW = DATAW / 8;

  arb_state_t       state;
  logic [IDXW-1:0]  rr_ptr;
  logic [IDXW-1:0]  grant;
  logic [NREQ-1:0]  grant_oh;
  logic [IDXW-1:0]  ptr_next;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_any;

  logic             pick_wr;
  logic [ADDRW-1:0] pick_addr;
  logic [DATAW-1:0] pick_wdata;
  logic [STRBW-1:0] pick_strb;

  scram_rr_picker #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_picker (
    .req     (req_en),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  // Steer the picked requester's command fields using the one-hot grant.
  always_comb begin
    pick_wr    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_strb  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        pick_wr    = req_wr[i];
        pick_addr  = req_addr[i*ADDRW +: ADDRW];
        pick_wdata = req_wdata[i*DATAW +: DATAW];
        pick_strb  = req_strb[i*STRBW +: STRBW];
      end
    end
  end

  assign ptr_next = (grant == IDXW'(NREQ - 1)) ? '0 : grant + 1'b1;

  // Access sequencer with registered RAM and requester outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      grant_oh  <= '0;
      ram_en    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_strb  <= '0;
      req_ready <= '0;
      req_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant     <= pick_idx;
            grant_oh  <= pick_gnt;
            ram_en    <= 1'b1;
            ram_wr    <= pick_wr;
            ram_addr  <= pick_addr;
            ram_wdata <= pick_wdata;
            ram_strb  <= pick_strb;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (ram_ready) begin
            req_rdata <= ram_rdata;
            req_ready <= grant_oh;
            rr_ptr    <= ptr_next;
            state     <= RESP;
          end
        end
        RESP: begin
          req_ready <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
